// File: rtl/l2_cache_ctrl_nway.sv
// N-way write-back/write-allocate L2 control FSM; optional perf counters under L2_PERF_CNT_EN.
// Latency: hit responds in the LOOKUP cycle after IDLE; miss adds FILL (and EVICT if dirty) then re-lookup.
// Backpressure: upstream holds mem_read/mem_write until mem_resp; EVICT waits on ewb_ready, FILL on pmem_resp.
module l2_cache_ctrl_nway #(
  parameter int WAYS     = 4,
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = 5,
  parameter int INDEX_W  = 4,
  localparam int WAY_W   = $clog2(WAYS),
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_address,
  output logic              mem_resp,
  input  logic [WAYS-1:0]   hit_vec,
  input  logic [WAYS-1:0]   valid_vec,
  input  logic [WAYS-1:0]   dirty_vec,
  input  logic [WAY_W-1:0]  lru_way,
  input  logic [TAG_W-1:0]  victim_tag,
  output logic [WAY_W-1:0]  victim_way,
  output logic [WAYS-1:0]   ld_data,
  output logic              data_sel_write,
  output logic              ld_tag,
  output logic [WAYS-1:0]   ld_dirty,
  output logic              dirty_in,
  output logic              ld_lru,
  output logic [WAY_W-1:0]  lru_touch_way,
  input  logic              ewb_ready,
  output logic              ewb_push,
  output logic [ADDR_W-1:0] ewb_addr,
  output logic              pmem_read,
  output logic [ADDR_W-1:0] pmem_address,
  input  logic              pmem_resp
`ifdef L2_PERF_CNT_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic [15:0]       wb_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, EVICT, FILL} state_t;

  state_t           state;
  logic [WAY_W-1:0] victim_q;
  logic             req;
  logic             any_hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] free_way;
  logic             has_free;
  logic [WAY_W-1:0] miss_way;
  logic             miss_dirty;
  logic             unused_offset;

  function automatic logic [WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
    logic [WAYS-1:0] v;
    v    = '0;
    v[w] = 1'b1;
    return v;
  endfunction

  assign req     = mem_read | mem_write;
  assign any_hit = |hit_vec;

  // Descending scan so the lowest matching index wins, including illegal multi-hot hits.
  always_comb begin
    hit_way  = '0;
    free_way = '0;
    has_free = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
      if (!valid_vec[i]) begin
        free_way = WAY_W'(i);
        has_free = 1'b1;
      end
    end
  end

  assign miss_way   = has_free ? free_way : lru_way;
  assign miss_dirty = valid_vec[miss_way] & dirty_vec[miss_way];

  assign ewb_addr      = {victim_tag, mem_address[OFFSET_W +: INDEX_W], {OFFSET_W{1'b0}}};
  assign pmem_address  = {mem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  assign unused_offset = ^mem_address[OFFSET_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      case (state)
        IDLE:   if (req) state <= LOOKUP;
        LOOKUP: begin
          if (!req || any_hit) begin
            state <= IDLE;
          end else begin
            victim_q <= miss_way;
            state    <= miss_dirty ? EVICT : FILL;
          end
        end
        EVICT:  if (ewb_ready) state <= FILL;
        FILL:   if (pmem_resp) state <= LOOKUP;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp       = 1'b0;
    victim_way     = '0;
    ld_data        = '0;
    data_sel_write = 1'b0;
    ld_tag         = 1'b0;
    ld_dirty       = '0;
    dirty_in       = 1'b0;
    ld_lru         = 1'b0;
    lru_touch_way  = '0;
    ewb_push       = 1'b0;
    pmem_read      = 1'b0;
    case (state)
      LOOKUP: begin
        if (req && any_hit) begin
          mem_resp      = 1'b1;
          ld_lru        = 1'b1;
          lru_touch_way = hit_way;
          if (mem_write) begin
            ld_data        = onehot(hit_way);
            data_sel_write = 1'b1;
            ld_dirty       = onehot(hit_way);
            dirty_in       = 1'b1;
          end
        end else if (req) begin
          victim_way = miss_way;
        end
      end
      EVICT: begin
        victim_way = victim_q;
        // Push and dirty-clear share the one cycle the EWB accepts the line.
        if (ewb_ready) begin
          ewb_push = 1'b1;
          ld_dirty = onehot(victim_q);
        end
      end
      FILL: begin
        victim_way = victim_q;
        pmem_read  = 1'b1;
        if (pmem_resp) begin
          ld_data  = onehot(victim_q);
          ld_tag   = 1'b1;
          ld_dirty = onehot(victim_q);
        end
      end
      default: ;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  // missed_q marks a request already counted as a miss so its re-lookup hit is not counted.
  logic missed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      missed_q <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (state == LOOKUP && req) begin
        if (any_hit) begin
          missed_q <= 1'b0;
          if (!missed_q && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          missed_q <= 1'b1;
          if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
      end else if (state == IDLE) begin
        missed_q <= 1'b0;
      end
      if (ewb_push && wb_cnt != 16'hFFFF) wb_cnt <= wb_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_cache_ctrl_nway.sv
// Directed bench for l2_cache_ctrl_nway at WAYS=4 with hand-computed expectations.
module tb_l2_cache_ctrl_nway;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_address = '0;
  logic        mem_resp;
  logic [3:0]  hit_vec = '0;
  logic [3:0]  valid_vec = '0;
  logic [3:0]  dirty_vec = '0;
  logic [1:0]  lru_way = '0;
  logic [6:0]  victim_tag = '0;
  logic [1:0]  victim_way;
  logic [3:0]  ld_data;
  logic        data_sel_write;
  logic        ld_tag;
  logic [3:0]  ld_dirty;
  logic        dirty_in;
  logic        ld_lru;
  logic [1:0]  lru_touch_way;
  logic        ewb_ready = 1'b0;
  logic        ewb_push;
  logic [15:0] ewb_addr;
  logic        pmem_read;
  logic [15:0] pmem_address;
  logic        pmem_resp = 1'b0;
`ifdef L2_PERF_CNT_EN
  logic [15:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int pushes = 0;

  l2_cache_ctrl_nway dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_resp(mem_resp), .hit_vec(hit_vec),
    .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_way(lru_way),
    .victim_tag(victim_tag), .victim_way(victim_way), .ld_data(ld_data),
    .data_sel_write(data_sel_write), .ld_tag(ld_tag), .ld_dirty(ld_dirty),
    .dirty_in(dirty_in), .ld_lru(ld_lru), .lru_touch_way(lru_touch_way),
    .ewb_ready(ewb_ready), .ewb_push(ewb_push), .ewb_addr(ewb_addr),
    .pmem_read(pmem_read), .pmem_address(pmem_address), .pmem_resp(pmem_resp)
`ifdef L2_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    tick();
    tick();
    reset       = 1'b0;
    mem_address = 16'h1234;
    settle();
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_ewb_push", ewb_push, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_victim_way", victim_way, 0);
    chk("rst_pmem_addr", pmem_address, 16'h1220);
    chk("rst_ewb_addr", ewb_addr, 16'h0020);

    // Read hit on way 2
    valid_vec = 4'b1111;
    hit_vec   = 4'b0100;
    mem_read  = 1'b1;
    settle();
    chk("rhit_idle_resp", mem_resp, 0);
    tick();
    chk("rhit_resp", mem_resp, 1);
    chk("rhit_ld_lru", ld_lru, 1);
    chk("rhit_touch", lru_touch_way, 2);
    chk("rhit_ld_data", ld_data, 0);
    chk("rhit_ld_dirty", ld_dirty, 0);
    tick();
    mem_read = 1'b0;
    settle();
    chk("rhit_after_resp", mem_resp, 0);

    // Write hit on way 0
    hit_vec   = 4'b0001;
    mem_write = 1'b1;
    tick();
    chk("whit_ld_data", ld_data, 4'b0001);
    chk("whit_sel", data_sel_write, 1);
    chk("whit_ld_dirty", ld_dirty, 4'b0001);
    chk("whit_dirty_in", dirty_in, 1);
    chk("whit_resp", mem_resp, 1);
    tick();
    mem_write = 1'b0;

    // Clean miss: first invalid way is 2
    hit_vec     = 4'b0000;
    valid_vec   = 4'b1011;
    dirty_vec   = 4'b0000;
    mem_address = 16'h1234;
    mem_read    = 1'b1;
    tick();
    chk("cmiss_victim", victim_way, 2);
    chk("cmiss_lookup_resp", mem_resp, 0);
    chk("cmiss_lookup_pread", pmem_read, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("cmiss_fill_pread", pmem_read, 1);
      chk("cmiss_fill_noload", ld_tag, 0);
      tick();
    end
    pmem_resp = 1'b1;
    settle();
    chk("cmiss_resp_pread", pmem_read, 1);
    chk("cmiss_ld_tag", ld_tag, 1);
    chk("cmiss_ld_data", ld_data, 4'b0100);
    chk("cmiss_ld_dirty", ld_dirty, 4'b0100);
    chk("cmiss_dirty_in", dirty_in, 0);
    chk("cmiss_sel", data_sel_write, 0);
    chk("cmiss_paddr", pmem_address, 16'h1220);
    chk("cmiss_fill_victim", victim_way, 2);
    tick();
    pmem_resp = 1'b0;
    hit_vec   = 4'b0100;
    valid_vec = 4'b1111;
    settle();
    chk("cmiss_relookup_resp", mem_resp, 1);
    chk("cmiss_relookup_touch", lru_touch_way, 2);
    chk("cmiss_relookup_pread", pmem_read, 0);
    tick();
    mem_read = 1'b0;

    // Dirty miss: all valid, LRU way 3 dirty, EWB stalls 3 cycles
    hit_vec     = 4'b0000;
    valid_vec   = 4'b1111;
    dirty_vec   = 4'b1000;
    lru_way     = 2'd3;
    victim_tag  = 7'h55;
    mem_address = 16'h1540;
    mem_write   = 1'b1;
    tick();
    chk("dmiss_victim", victim_way, 3);
    chk("dmiss_lookup_resp", mem_resp, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (ewb_push) pushes++;
      chk("dmiss_stall_push", ewb_push, 0);
      chk("dmiss_stall_dirty", ld_dirty, 0);
      tick();
    end
    ewb_ready = 1'b1;
    settle();
    if (ewb_push) pushes++;
    chk("dmiss_push", ewb_push, 1);
    chk("dmiss_ewb_addr", ewb_addr, 16'hAB40);
    chk("dmiss_clr_dirty", ld_dirty, 4'b1000);
    chk("dmiss_dirty_in", dirty_in, 0);
    chk("dmiss_evict_pread", pmem_read, 0);
    tick();
    dirty_vec = 4'b0000;
    pmem_resp = 1'b1;
    settle();
    if (ewb_push) pushes++;
    chk("dmiss_fill_push", ewb_push, 0);
    chk("dmiss_fill_pread", pmem_read, 1);
    chk("dmiss_fill_paddr", pmem_address, 16'h1540);
    chk("dmiss_fill_ld_data", ld_data, 4'b1000);
    chk("dmiss_fill_ld_tag", ld_tag, 1);
    tick();
    pmem_resp = 1'b0;
    ewb_ready = 1'b0;
    hit_vec   = 4'b1000;
    settle();
    chk("dmiss_merge_ld_data", ld_data, 4'b1000);
    chk("dmiss_merge_sel", data_sel_write, 1);
    chk("dmiss_merge_dirty_in", dirty_in, 1);
    chk("dmiss_merge_resp", mem_resp, 1);
    chk("dmiss_push_count", pushes, 1);
    tick();
    mem_write = 1'b0;

`ifdef L2_PERF_CNT_EN
    chk("perf_hit_cnt", hit_cnt, 2);
    chk("perf_miss_cnt", miss_cnt, 2);
    chk("perf_wb_cnt", wb_cnt, 1);
`endif

    // Request withdrawn during LOOKUP: no response
    hit_vec  = 4'b0010;
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    settle();
    chk("drop_resp", mem_resp, 0);
    chk("drop_ld_lru", ld_lru, 0);
    tick();

    // Reset in the 2nd FILL cycle
    hit_vec     = 4'b0000;
    valid_vec   = 4'b0111;
    mem_address = 16'h2000;
    mem_read    = 1'b1;
    tick();
    chk("rstfill_victim", victim_way, 3);
    tick();
    chk("rstfill_fill1_pread", pmem_read, 1);
    tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    mem_read = 1'b0;
    settle();
    chk("rstfill_pread", pmem_read, 0);
    chk("rstfill_ld_tag", ld_tag, 0);
    chk("rstfill_ld_data", ld_data, 0);
    chk("rstfill_ld_dirty", ld_dirty, 0);
    chk("rstfill_victim_way", victim_way, 0);

    // New request after reset, multi-hot hit resolves to lowest way
    valid_vec = 4'b1111;
    hit_vec   = 4'b0110;
    mem_read  = 1'b1;
    settle();
    chk("post_idle_resp", mem_resp, 0);
    tick();
    chk("post_resp", mem_resp, 1);
    chk("post_touch", lru_touch_way, 1);
    tick();
    mem_read = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
